// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares a single DMA read engine between three loaders
// (bias, weight, ifmap) using round-robin arbitration. One transfer is in
// flight at a time. Every output is registered.
module dma_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [2:0]            req_i,
    input  logic [3*ADDR_W-1:0]   addr_i,
    input  logic [3*LEN_W-1:0]    len_i,
    output logic [2:0]            gnt_o,
    output logic [2:0]            done_o,
    output logic                  dma_start,
    output logic [ADDR_W-1:0]     dma_addr,
    output logic [LEN_W-1:0]      dma_len,
    input  logic                  dma_done,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              state_reg;
    logic [1:0]          ptr_reg;
    logic [1:0]          owner_reg;
    logic [2:0]          gnt_reg;
    logic [2:0]          done_reg;
    logic                start_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [LEN_W-1:0]    len_reg;
    logic                busy_reg;

    logic [ADDR_W-1:0]   addr_arr [0:2];
    logic [LEN_W-1:0]    len_arr  [0:2];

    logic                sel_valid;
    logic [1:0]          sel_idx;

    // Index arithmetic modulo three. There are only three requesters, so the
    // value 3 never reaches the state registers.
    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] s;
        s = {1'b0, base} + {1'b0, off};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Split the packed per-requester buses into arrays so they can be indexed.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
            assign addr_arr[gi] = addr_i[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = len_i[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Round-robin pick. The loop runs from the farthest offset down to ptr, so
    // the last match it records is the nearest set bit at or above ptr.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (req_i[wrap_add(ptr_reg, 2'(i))]) begin
                sel_valid = 1'b1;
                sel_idx   = wrap_add(ptr_reg, 2'(i));
            end
        end
    end

    // Arbitration FSM. Every output is a register and is updated together
    // with the state.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 2'd0;
            owner_reg <= 2'd0;
            gnt_reg   <= 3'b000;
            done_reg  <= 3'b000;
            start_reg <= 1'b0;
            addr_reg  <= '0;
            len_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            // Default: both pulse outputs last a single cycle.
            start_reg <= 1'b0;
            done_reg  <= 3'b000;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_valid) begin
                        owner_reg <= sel_idx;
                        busy_reg  <= 1'b1;
                        if (len_arr[sel_idx] != '0) begin
                            state_reg <= ST_ISSUE;
                            gnt_reg   <= onehot(sel_idx);
                            start_reg <= 1'b1;
                            addr_reg  <= addr_arr[sel_idx];
                            len_reg   <= len_arr[sel_idx];
                        end else begin
                            // A zero-length request completes at once and
                            // never reaches the DMA engine.
                            state_reg <= ST_RELEASE;
                            done_reg  <= onehot(sel_idx);
                            ptr_reg   <= wrap_add(sel_idx, 2'd1);
                        end
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dma_done) begin
                        state_reg <= ST_RELEASE;
                        done_reg  <= onehot(owner_reg);
                        gnt_reg   <= 3'b000;
                        addr_reg  <= '0;
                        len_reg   <= '0;
                        ptr_reg   <= wrap_add(owner_reg, 2'd1);
                    end
                end
                ST_RELEASE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_reg;
    assign done_o    = done_reg;
    assign dma_start = start_reg;
    assign dma_addr  = addr_reg;
    assign dma_len   = len_reg;
    assign busy_o    = busy_reg;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed testbench for dma_rd_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_dma_rd_arbiter;

    localparam int AW = 32;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic [2:0]      req_i;
    logic [3*AW-1:0] addr_i;
    logic [3*LW-1:0] len_i;
    logic [2:0]      gnt_o;
    logic [2:0]      done_o;
    logic            dma_start;
    logic [AW-1:0]   dma_addr;
    logic [LW-1:0]   dma_len;
    logic            dma_done;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_rd_arbiter #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_i     (req_i),
        .addr_i    (addr_i),
        .len_i     (len_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .dma_start (dma_start),
        .dma_addr  (dma_addr),
        .dma_len   (dma_len),
        .dma_done  (dma_done),
        .busy_o    (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_src(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
        addr_i[k*AW +: AW] = a;
        len_i[k*LW +: LW]  = l;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_gnt"},   gnt_o,     3'b000);
        check({tag, "_done"},  done_o,    3'b000);
        check({tag, "_start"}, dma_start, 1'b0);
        check({tag, "_addr"},  dma_addr,  '0);
        check({tag, "_len"},   dma_len,   '0);
        check({tag, "_busy"},  busy_o,    1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        step();
        step();
        rstn = 1'b0;
    endtask

    // One full transfer, started from IDLE, with an expected owner.
    task automatic xfer(input logic [2:0] req, input int owner, input logic [AW-1:0] a,
                        input logic [LW-1:0] l, input logic [2:0] req_after);
        logic [2:0] oh;
        oh = 3'b001 << owner;
        req_i = req;
        set_src(owner, a, l);
        step();
        check("issue_gnt",   gnt_o,     oh);
        check("issue_start", dma_start, 1'b1);
        check("issue_addr",  dma_addr,  a);
        check("issue_len",   dma_len,   l);
        check("issue_busy",  busy_o,    1'b1);
        check("issue_done",  done_o,    3'b000);
        step();
        check("wait_start",  dma_start, 1'b0);
        check("wait_gnt",    gnt_o,     oh);
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("rel_done",    done_o,    oh);
        check("rel_gnt",     gnt_o,     3'b000);
        check("rel_busy",    busy_o,    1'b1);
        req_i = req_after;
        step();
        check("idle_done",   done_o,    3'b000);
        check("idle_busy",   busy_o,    1'b0);
        $display("xfer req=%b owner=%0d addr=0x%0h len=%0d", req, owner, a, l);
    endtask

    initial begin
        rstn     = 1'b0;
        req_i    = 3'b000;
        addr_i   = '0;
        len_i    = '0;
        dma_done = 1'b0;
        step();

        // Reset state
        do_reset();
        check_idle_zero("reset");
        $display("reset: outputs checked");

        // Single request from the weight loader
        xfer(3'b010, 1, 32'h1000, 16'd64, 3'b000);

        // Round robin with all three requests held high
        do_reset();
        set_src(0, 32'hA000, 16'd8);
        set_src(1, 32'hB000, 16'd16);
        set_src(2, 32'hC000, 16'd24);
        xfer(3'b111, 0, 32'hA000, 16'd8,  3'b111);
        xfer(3'b111, 1, 32'hB000, 16'd16, 3'b111);
        xfer(3'b111, 2, 32'hC000, 16'd24, 3'b111);
        xfer(3'b111, 0, 32'hA000, 16'd8,  3'b000);

        // Zero-length request: immediate done, no DMA launch, ptr moves to 1
        do_reset();
        req_i = 3'b001;
        set_src(0, 32'h7000, 16'd0);
        step();
        check("zl_done",  done_o,    3'b001);
        check("zl_start", dma_start, 1'b0);
        check("zl_gnt",   gnt_o,     3'b000);
        check("zl_busy",  busy_o,    1'b1);
        req_i = 3'b000;
        step();
        check("zl_idle_done",  done_o,    3'b000);
        check("zl_idle_start", dma_start, 1'b0);
        check("zl_idle_busy",  busy_o,    1'b0);
        $display("zero-length: owner=0 done pulse checked");
        // ptr is now 1, so requester 1 must win over requester 0
        xfer(3'b011, 1, 32'h2000, 16'd4, 3'b000);

        // Stray dma_done in IDLE and in ISSUE (ptr is 2 here)
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("stray_idle_busy", busy_o, 1'b0);
        check("stray_idle_done", done_o, 3'b000);
        check("stray_idle_gnt",  gnt_o,  3'b000);
        req_i = 3'b100;
        set_src(2, 32'h3000, 16'd5);
        step();
        check("stray_issue_gnt", gnt_o, 3'b100);
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("stray_wait_done",  done_o,    3'b000);
        check("stray_wait_gnt",   gnt_o,     3'b100);
        check("stray_wait_busy",  busy_o,    1'b1);
        check("stray_wait_start", dma_start, 1'b0);
        step();
        check("stray_hold_gnt",  gnt_o,  3'b100);
        check("stray_hold_done", done_o, 3'b000);
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("stray_rel_done", done_o, 3'b100);
        req_i = 3'b000;
        step();
        check("stray_idle2_busy", busy_o, 1'b0);
        $display("stray done: owner=2 addr=0x3000 len=5 checked");

        // Input stability during WAIT, with the request dropped (ptr is 0)
        req_i = 3'b001;
        set_src(0, 32'h4000, 16'd12);
        step();
        check("stab_start", dma_start, 1'b1);
        step();
        set_src(0, 32'hDEAD, 16'd99);
        req_i = 3'b000;
        step();
        check("stab_addr1", dma_addr, 32'h4000);
        check("stab_len1",  dma_len,  16'd12);
        check("stab_gnt1",  gnt_o,    3'b001);
        step();
        check("stab_addr2", dma_addr, 32'h4000);
        check("stab_len2",  dma_len,  16'd12);
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("stab_done", done_o, 3'b001);
        step();
        check("stab_idle_busy", busy_o, 1'b0);
        $display("stability: addr held at 0x4000 while inputs read 0xDEAD");

        // Reset during WAIT with owner 2 (ptr is 1 before the reset)
        req_i = 3'b100;
        set_src(2, 32'h5000, 16'd7);
        step();
        check("rw_issue_gnt", gnt_o, 3'b100);
        step();
        req_i = 3'b000;
        rstn  = 1'b1;
        step();
        rstn  = 1'b0;
        check_idle_zero("rw_reset");
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("rw_stray_done", done_o, 3'b000);
        check("rw_stray_busy", busy_o, 1'b0);
        $display("reset mid-wait: transfer abandoned");
        // ptr was reset to 0: requester 0 wins over requester 2
        xfer(3'b101, 0, 32'h6000, 16'd3, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
